mem_responder_8085: RTL and testbench

//  Memory/IO slave for the multiplexed 8085 bus: the responder end of the CPU's bus cycles.

---
 rtl/mem_responder_8085_if.sv | 23 ++
 rtl/mem_responder_8085.sv | 198 +++++++++++++++++++
 tb/tb_mem_responder_8085.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_8085_if.sv
// rtl/mem_responder_8085_if.sv - 8085 multiplexed bus signals between CPU (master) and responder (slave)
interface mem_responder_8085_if;
  logic       ale;
  logic       rd_n;
  logic       wr_n;
  logic       io_m;
  logic [7:0] a_hi;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       ready;
  logic       bus_err;

  modport master (
    output ale, rd_n, wr_n, io_m, a_hi, ad_in,
    input  ad_out, ad_oe, ready, bus_err
  );

  modport slave (
    input  ale, rd_n, wr_n, io_m, a_hi, ad_in,
    output ad_out, ad_oe, ready, bus_err
  );
endinterface

// File: rtl/mem_responder_8085.sv
// rtl/mem_responder_8085.sv - 8085 bus memory/IO responder with wait states; optional IO_PORTS_EN io[] array
module mem_responder_8085 #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_8085_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        cyc_io_q, cyc_io_d;
  logic        is_read_q, is_read_d;
  logic        wrote_q, wrote_d;
  logic        dual_q, dual_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        ad_oe_q, ad_oe_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        bus_err_q, bus_err_d;

  logic        wr_fire;
  logic        mem_we;
  logic        rd_ok;
  logic [7:0]  rd_data;
  logic        strb_any;
  logic        strb_dual;
  logic        unused_addr;

  wire [ADDR_W-1:0] idx = addr_q[ADDR_W-1:0];

  // Upper address bits only alias into the array; keep them visibly consumed
  assign unused_addr = ^addr_q;

  assign strb_any  = !bus.rd_n || !bus.wr_n;
  assign strb_dual = !bus.rd_n && !bus.wr_n;

`ifdef IO_PORTS_EN
  logic [7:0] io [0:255];
  logic       io_we;

  assign rd_data = cyc_io_q ? io[addr_q[7:0]] : mem[idx];
  assign rd_ok   = 1'b1;
  assign io_we   = wr_fire && cyc_io_q;

  // IO port array write, one byte per completed IO write cycle
  always_ff @(posedge clk) begin
    if (io_we) io[addr_q[7:0]] <= bus.ad_in;
  end
`else
  // IO cycles without a port array: handshake completes but the bus floats
  assign rd_data = mem[idx];
  assign rd_ok   = !cyc_io_q;
`endif

  assign mem_we = wr_fire && !cyc_io_q;

  // Memory array write; no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= bus.ad_in;
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 16'h0000;
      cyc_io_q  <= 1'b0;
      is_read_q <= 1'b0;
      wrote_q   <= 1'b0;
      dual_q    <= 1'b0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_out_q  <= 8'h00;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cyc_io_q  <= cyc_io_d;
      is_read_q <= is_read_d;
      wrote_q   <= wrote_d;
      dual_q    <= dual_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      ad_oe_q   <= ad_oe_d;
      ad_out_q  <= ad_out_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and next-output logic for the bus cycle sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cyc_io_d  = cyc_io_q;
    is_read_d = is_read_q;
    wrote_d   = wrote_q;
    dual_d    = dual_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    ad_oe_d   = ad_oe_q;
    ad_out_d  = ad_out_q;
    bus_err_d = 1'b0;
    wr_fire   = 1'b0;

    if (state_q == S_IDLE) begin
      ready_d = 1'b1;
      ad_oe_d = 1'b0;
      if (bus.ale) begin
        addr_d   = {bus.a_hi, bus.ad_in};
        cyc_io_d = bus.io_m;
        wrote_d  = 1'b0;
        dual_d   = 1'b0;
        state_d  = S_ADDR;
      end else if (strb_any) begin
        // Strobe with no address phase: flag it and stay idle
        bus_err_d = 1'b1;
      end
    end else if (bus.ale) begin
      // New address phase abandons whatever cycle was in flight
      addr_d   = {bus.a_hi, bus.ad_in};
      cyc_io_d = bus.io_m;
      wrote_d  = 1'b0;
      dual_d   = 1'b0;
      ready_d  = 1'b1;
      ad_oe_d  = 1'b0;
      state_d  = S_ADDR;
    end else begin
      // Both strobes low is reported once per cycle and handled as a read
      if (strb_dual && !dual_q) begin
        bus_err_d = 1'b1;
        dual_d    = 1'b1;
      end

      case (state_q)
        S_ADDR: begin
          if (strb_any) begin
            is_read_d = !bus.rd_n;
            if (WAIT_STATES > 0) begin
              ready_d = 1'b0;
              cnt_d   = WAIT_LOAD;
              state_d = S_WAIT;
            end else begin
              state_d = S_DATA;
              if (!bus.rd_n && rd_ok) begin
                ad_out_d = rd_data;
                ad_oe_d  = 1'b1;
              end
            end
          end
        end

        S_WAIT: begin
          if (!strb_any) begin
            ready_d   = 1'b1;
            bus_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (cnt_q == 4'd0) begin
            ready_d = 1'b1;
            state_d = S_DATA;
            if (is_read_q && rd_ok) begin
              ad_out_d = rd_data;
              ad_oe_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        S_DATA: begin
          if (!strb_any) begin
            ad_oe_d = 1'b0;
            state_d = S_IDLE;
          end else if (!is_read_q && !bus.wr_n && bus.rd_n && !wrote_q) begin
            wr_fire = 1'b1;
            wrote_d = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.ad_oe   = ad_oe_q;
  assign bus.ad_out  = ad_out_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_responder_8085.sv
// tb/tb_mem_responder_8085.sv - directed bench for mem_responder_8085 at 0, 3 and 4 wait states
module tb_mem_responder_8085;

  logic       clk;
  logic       rst_n;
  logic       ale;
  logic       rd_n;
  logic       wr_n;
  logic       io_m;
  logic [7:0] a_hi;
  logic [7:0] ad_in;

  int chk_cnt;
  int pass_cnt;

  mem_responder_8085_if bus0 ();
  mem_responder_8085_if bus3 ();
  mem_responder_8085_if bus4 ();

  assign bus0.ale = ale;  assign bus0.rd_n = rd_n;  assign bus0.wr_n = wr_n;
  assign bus0.io_m = io_m; assign bus0.a_hi = a_hi; assign bus0.ad_in = ad_in;
  assign bus3.ale = ale;  assign bus3.rd_n = rd_n;  assign bus3.wr_n = wr_n;
  assign bus3.io_m = io_m; assign bus3.a_hi = a_hi; assign bus3.ad_in = ad_in;
  assign bus4.ale = ale;  assign bus4.rd_n = rd_n;  assign bus4.wr_n = wr_n;
  assign bus4.io_m = io_m; assign bus4.a_hi = a_hi; assign bus4.ad_in = ad_in;

  mem_responder_8085 #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_responder_8085 #(.ADDR_W(10), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  mem_responder_8085 #(.ADDR_W(10), .WAIT_STATES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ale(input logic io, input logic [15:0] addr);
    ale   = 1'b1;
    io_m  = io;
    a_hi  = addr[15:8];
    ad_in = addr[7:0];
    tick();
    ale = 1'b0;
  endtask

  task automatic release_bus();
    rd_n = 1'b1;
    wr_n = 1'b1;
    ale  = 1'b0;
    io_m = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk_cnt++; if (bus0.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus0.ready); else pass_cnt++;
    chk_cnt++; if (bus3.ad_oe !== 1'b0) $display("FAIL reset_ad_oe got %b want 0", bus3.ad_oe); else pass_cnt++;
    chk_cnt++; if (bus0.ad_out !== 8'h00) $display("FAIL reset_ad_out got %h want 00", bus0.ad_out); else pass_cnt++;
    chk_cnt++; if (bus4.bus_err !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus4.bus_err); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_zero_wait();
    dut0.mem[5] = 8'h3E;
    do_ale(1'b0, 16'h0005);
    rd_n = 1'b0;
    tick();
    chk_cnt++; if (bus0.ad_oe !== 1'b1) $display("FAIL t1_ad_oe got %b want 1", bus0.ad_oe); else pass_cnt++;
    chk_cnt++; if (bus0.ad_out !== 8'h3E) $display("FAIL t1_ad_out got %h want 3e", bus0.ad_out); else pass_cnt++;
    chk_cnt++; if (bus0.ready !== 1'b1) $display("FAIL t1_ready got %b want 1", bus0.ready); else pass_cnt++;
    tick();
    chk_cnt++; if (bus0.ad_oe !== 1'b1) $display("FAIL t1_ad_oe_hold got %b want 1", bus0.ad_oe); else pass_cnt++;
    rd_n = 1'b1;
    tick();
    chk_cnt++; if (bus0.ad_oe !== 1'b0) $display("FAIL t1_ad_oe_end got %b want 0", bus0.ad_oe); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_wait_states();
    int  lows;
    bit  done;
    // write A5 to 0123 through three wait states
    dut3.mem[10'h123] = 8'h00;
    do_ale(1'b0, 16'h0123);
    wr_n  = 1'b0;
    ad_in = 8'hA5;
    lows = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (bus3.ready === 1'b0) lows++;
      else if (lows > 0) done = 1;
    end
    chk_cnt++; if (!done) $display("FAIL t2_wr_ready_timeout lows %0d want 3", lows); else pass_cnt++;
    chk_cnt++; if (lows !== 3) $display("FAIL t2_wr_ready_low got %0d want 3", lows); else pass_cnt++;
    tick();
    ad_in = 8'hFF;
    tick();
    tick();
    chk_cnt++; if (dut3.mem[10'h123] !== 8'hA5) $display("FAIL t2_single_write got %h want a5", dut3.mem[10'h123]); else pass_cnt++;
    release_bus();
    // read it back
    do_ale(1'b0, 16'h0123);
    rd_n = 1'b0;
    lows = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (bus3.ready === 1'b0) lows++;
      else if (lows > 0) done = 1;
    end
    chk_cnt++; if (lows !== 3) $display("FAIL t2_rd_ready_low got %0d want 3", lows); else pass_cnt++;
    chk_cnt++; if (bus3.ad_out !== 8'hA5) $display("FAIL t2_readback got %h want a5", bus3.ad_out); else pass_cnt++;
    chk_cnt++; if (bus3.ad_oe !== 1'b1) $display("FAIL t2_rd_ad_oe got %b want 1", bus3.ad_oe); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_aliasing();
    do_ale(1'b0, 16'h0405);
    wr_n  = 1'b0;
    ad_in = 8'h77;
    tick();
    tick();
    wr_n = 1'b1;
    tick();
    chk_cnt++; if (dut0.mem[10'h005] !== 8'h77) $display("FAIL t3_alias_store got %h want 77", dut0.mem[10'h005]); else pass_cnt++;
    do_ale(1'b0, 16'h0005);
    rd_n = 1'b0;
    tick();
    chk_cnt++; if (bus0.ad_out !== 8'h77) $display("FAIL t3_alias_read got %h want 77", bus0.ad_out); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_dual_strobe();
    dut0.mem[10'h020] = 8'h11;
    do_ale(1'b0, 16'h0020);
    rd_n  = 1'b0;
    wr_n  = 1'b0;
    ad_in = 8'hEE;
    tick();
    chk_cnt++; if (bus0.bus_err !== 1'b1) $display("FAIL t4_err_pulse got %b want 1", bus0.bus_err); else pass_cnt++;
    chk_cnt++; if (bus0.ad_out !== 8'h11) $display("FAIL t4_read_data got %h want 11", bus0.ad_out); else pass_cnt++;
    tick();
    chk_cnt++; if (bus0.bus_err !== 1'b0) $display("FAIL t4_err_width got %b want 0", bus0.bus_err); else pass_cnt++;
    chk_cnt++; if (bus0.ad_oe !== 1'b1) $display("FAIL t4_ad_oe got %b want 1", bus0.ad_oe); else pass_cnt++;
    rd_n = 1'b1;
    wr_n = 1'b1;
    tick();
    chk_cnt++; if (dut0.mem[10'h020] !== 8'h11) $display("FAIL t4_no_write got %h want 11", dut0.mem[10'h020]); else pass_cnt++;
    // strobe in IDLE with no address phase
    rd_n = 1'b0;
    tick();
    chk_cnt++; if (bus0.bus_err !== 1'b1) $display("FAIL idle_strobe_err got %b want 1", bus0.bus_err); else pass_cnt++;
    chk_cnt++; if (bus0.ad_oe !== 1'b0) $display("FAIL idle_strobe_ad_oe got %b want 0", bus0.ad_oe); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_reset_mid_cycle();
    dut4.mem[10'h040] = 8'h99;
    do_ale(1'b0, 16'h0040);
    wr_n  = 1'b0;
    ad_in = 8'h55;
    tick();
    tick();
    chk_cnt++; if (bus4.ready !== 1'b0) $display("FAIL t5_in_wait got %b want 0", bus4.ready); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus4.ready !== 1'b1) $display("FAIL t5_async_ready got %b want 1", bus4.ready); else pass_cnt++;
    chk_cnt++; if (bus4.ad_oe !== 1'b0) $display("FAIL t5_async_ad_oe got %b want 0", bus4.ad_oe); else pass_cnt++;
    tick();
    wr_n = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();
    chk_cnt++; if (dut4.mem[10'h040] !== 8'h99) $display("FAIL t5_write_dropped got %h want 99", dut4.mem[10'h040]); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_abort();
    dut3.mem[10'h050] = 8'h5C;
    dut3.mem[10'h060] = 8'h6B;
    do_ale(1'b0, 16'h0050);
    wr_n  = 1'b0;
    ad_in = 8'hC3;
    tick();
    wr_n = 1'b1;
    do_ale(1'b0, 16'h0060);
    chk_cnt++; if (bus3.ready !== 1'b1) $display("FAIL ale_abort_ready got %b want 1", bus3.ready); else pass_cnt++;
    rd_n = 1'b0;
    tick();
    chk_cnt++; if (bus3.ready !== 1'b0) $display("FAIL ale_reacc_wait got %b want 0", bus3.ready); else pass_cnt++;
    tick();
    tick();
    tick();
    chk_cnt++; if (bus3.ad_out !== 8'h6B) $display("FAIL ale_reacc_data got %h want 6b", bus3.ad_out); else pass_cnt++;
    chk_cnt++; if (dut3.mem[10'h050] !== 8'h5C) $display("FAIL ale_abort_nowrite got %h want 5c", dut3.mem[10'h050]); else pass_cnt++;
    release_bus();
    // strobe released during WAIT
    do_ale(1'b0, 16'h0070);
    rd_n = 1'b0;
    tick();
    rd_n = 1'b1;
    tick();
    chk_cnt++; if (bus3.bus_err !== 1'b1) $display("FAIL early_release_err got %b want 1", bus3.bus_err); else pass_cnt++;
    chk_cnt++; if (bus3.ready !== 1'b1) $display("FAIL early_release_ready got %b want 1", bus3.ready); else pass_cnt++;
    release_bus();
  endtask

  task automatic test_io_cycle();
    dut0.mem[10'h010] = 8'h01;
    do_ale(1'b1, 16'h1010);
    wr_n  = 1'b0;
    ad_in = 8'h5A;
    tick();
    tick();
    wr_n = 1'b1;
    tick();
    do_ale(1'b1, 16'h1010);
    io_m = 1'b0;
    rd_n = 1'b0;
    tick();
    chk_cnt++; if (bus0.ready !== 1'b1) $display("FAIL t6_ready got %b want 1", bus0.ready); else pass_cnt++;
`ifdef IO_PORTS_EN
    chk_cnt++; if (bus0.ad_oe !== 1'b1) $display("FAIL t6_ad_oe got %b want 1", bus0.ad_oe); else pass_cnt++;
    chk_cnt++; if (bus0.ad_out !== 8'h5A) $display("FAIL t6_io_read got %h want 5a", bus0.ad_out); else pass_cnt++;
`else
    chk_cnt++; if (bus0.ad_oe !== 1'b0) $display("FAIL t6_ad_oe got %b want 0", bus0.ad_oe); else pass_cnt++;
    tick();
    chk_cnt++; if (bus0.ad_oe !== 1'b0) $display("FAIL t6_ad_oe_hold got %b want 0", bus0.ad_oe); else pass_cnt++;
`endif
    release_bus();
    chk_cnt++; if (dut0.mem[10'h010] !== 8'h01) $display("FAIL t6_mem_untouched got %h want 01", dut0.mem[10'h010]); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n = 1'b0;
    ale   = 1'b0;
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    io_m  = 1'b0;
    a_hi  = 8'h00;
    ad_in = 8'h00;
    test_reset();
    test_read_zero_wait();
    test_wait_states();
    test_aliasing();
    test_dual_strobe();
    test_reset_mid_cycle();
    test_abort();
    test_io_cycle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
